// File: rtl/trigger_monitor_pkg.sv
// Shared types and constants for the trigger generator/monitor pair.
// The default period is common to both ends of the trigger line.
package trigger_pkg;

    localparam int TRIG_PERIOD_DEF = 2;

    typedef enum logic [1:0] {
        HUNT,
        ACQ,
        LOCKED,
        RESYNC
    } trig_mon_state_t;

endpackage

// File: rtl/trigger_monitor_if.sv
// Trigger line bundle between generator (master) and monitor (slave).
// Carries the trigger pulse forward and status/resync back.
interface trigger_monitor_if #(
    parameter int CW = 8
);
    logic          trigger;
    logic          nul;
    logic          locked;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          err;

    modport master (
        output trigger,
        input  nul,
        input  locked,
        input  period,
        input  period_valid,
        input  err
    );

    modport slave (
        input  trigger,
        output nul,
        output locked,
        output period,
        output period_valid,
        output err
    );
endinterface

// File: rtl/trig_edge_sync.sv
// Two-flop synchroniser for the asynchronous trigger plus a third
// flop for rising-edge detection.
module trig_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sh <= '0;
        else      sh <= {sh[1:0], din};
    end

    assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/trigger_monitor.sv
// Measures trigger spacing, locks onto period N and requests a
// generator resync via nul when lock is lost.
module trigger_monitor
    import trigger_pkg::*;
#(
    parameter int N        = TRIG_PERIOD_DEF,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int ERR_MAX  = 2,
    parameter int NUL_LEN  = 3,
    parameter int CW       = 8
) (
    input logic         clk,
    input logic         rst,
    trigger_monitor_if.slave bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam int LW = $clog2(NUL_LEN + 1);

    localparam logic [CW-1:0] P_LO  = CW'(N - TOL);
    localparam logic [CW-1:0] P_HI  = CW'(N + TOL);
    localparam logic [CW-1:0] T_MAX = CW'(2 * N + 1);

    logic            rise;
    logic            tmo;
    logic            good;
    logic [CW-1:0]   cnt;

    trig_mon_state_t state, state_nx;
    logic [GW-1:0]   good_cnt, good_nx;
    logic [EW-1:0]   err_cnt, err_nx;
    logic [LW-1:0]   nul_cnt, nul_nx;
    logic            pub;
    logic            bad_ev;

    logic [CW-1:0]   period_q;
    logic            pv_q;
    logic            err_q;
    logic            locked_q;
    logic            nul_q;

    trig_edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.trigger),
        .rise (rise)
    );

    // An edge in the timeout cycle takes priority over the timeout.
    assign tmo  = (cnt == T_MAX) && !rise;
    assign good = (cnt >= P_LO) && (cnt <= P_HI);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              cnt <= '0;
        else if (rise)         cnt <= CW'(1);
        else if (cnt == T_MAX) cnt <= CW'(1);
        else                   cnt <= cnt + CW'(1);
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        err_nx   = err_cnt;
        nul_nx   = nul_cnt;
        pub      = 1'b0;
        bad_ev   = 1'b0;
        unique case (state)
            HUNT: begin
                if (rise) begin
                    state_nx = ACQ;
                    good_nx  = '0;
                end
            end
            ACQ: begin
                if (rise) begin
                    pub = 1'b1;
                    if (good) begin
                        good_nx = good_cnt + GW'(1);
                        if (good_cnt == GW'(LOCK_CNT - 1)) begin
                            state_nx = LOCKED;
                            err_nx   = '0;
                        end
                    end else begin
                        good_nx = '0;
                    end
                end else if (tmo) begin
                    state_nx = HUNT;
                end
            end
            LOCKED: begin
                if (rise) begin
                    pub    = 1'b1;
                    bad_ev = !good;
                end else begin
                    bad_ev = tmo;
                end
                if (rise && good) begin
                    err_nx = '0;
                end else if (bad_ev) begin
                    err_nx = err_cnt + EW'(1);
                    if (err_cnt == EW'(ERR_MAX - 1)) begin
                        state_nx = RESYNC;
                        nul_nx   = '0;
                    end
                end
            end
            RESYNC: begin
                if (nul_cnt == LW'(NUL_LEN - 1)) state_nx = HUNT;
                else                             nul_nx   = nul_cnt + LW'(1);
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            good_cnt <= '0;
            err_cnt  <= '0;
            nul_cnt  <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            err_cnt  <= err_nx;
            nul_cnt  <= nul_nx;
        end
    end

    // Status flags follow the state register by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= '0;
            pv_q     <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            nul_q    <= 1'b0;
        end else begin
            if (pub) period_q <= cnt;
            pv_q     <= pub;
            err_q    <= bad_ev;
            locked_q <= (state == LOCKED);
            nul_q    <= (state == RESYNC);
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.err          = err_q;
    assign bus.locked       = locked_q;
    assign bus.nul          = nul_q;
endmodule
